// File: rtl/tmr_fault_monitor_pkg.sv
// Shared definitions for the TMR fault monitor: voter outcome codes,
// FSM state encoding, vote classification helpers and log entry width.
package tmr_fault_monitor_pkg;

  localparam logic [2:0] VOTE_AGREE = 3'b000;
  localparam logic [2:0] VOTE_A     = 3'b001;
  localparam logic [2:0] VOTE_B     = 3'b010;
  localparam logic [2:0] VOTE_C     = 3'b100;
  localparam logic [2:0] VOTE_NOMAJ = 3'b111;

  localparam int unsigned LOG_STAMP_W = 16;
  localparam int unsigned LOG_W       = LOG_STAMP_W + 3;

  typedef enum logic [2:0] {
    ST_MONITOR,
    ST_SUSPECT,
    ST_RESYNC_REQ,
    ST_RESYNC_WAIT,
    ST_FATAL
  } state_e;

  typedef enum logic [1:0] {
    V_AGREE,
    V_SINGLE,
    V_NOMAJ
  } vote_kind_e;

  // Any code other than the four defined outcomes counts as no majority.
  function automatic vote_kind_e classify_vote(input logic [2:0] v);
    vote_kind_e k;
    case (v)
      VOTE_AGREE:               k = V_AGREE;
      VOTE_A, VOTE_B, VOTE_C:   k = V_SINGLE;
      default:                  k = V_NOMAJ;
    endcase
    return k;
  endfunction

  // One-hot {C,B,A} of the outvoted core, or zero when not a single-core outvote.
  function automatic logic [2:0] outvoted_core(input logic [2:0] v);
    logic [2:0] h;
    case (v)
      VOTE_A, VOTE_B, VOTE_C: h = v;
      default:                h = '0;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/tmr_fault_monitor_log_fifo.sv
// Four-entry event FIFO for the fault log. Present only when FAULT_LOG_EN
// is defined. A write into a full FIFO is dropped and latches overflow,
// unless a read in the same cycle frees a slot.
`ifdef FAULT_LOG_EN
module fault_log_fifo
  import tmr_fault_monitor_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = LOG_W
) (
  input  logic         clk,
  input  logic         rst_in,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         overflow
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             full;
  logic             do_rd;
  logic             do_wr;

  // Read only when data exists; write when room exists or a read frees a slot.
  always_comb begin
    full    = (occ == OCC_W'(DEPTH));
    empty   = (occ == '0);
    do_rd   = rd_en && !empty;
    do_wr   = wr_en && (!full || do_rd);
    rd_data = mem[rd_ptr];
  end

  // Storage array, written at the tail.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
      if (wr_en && !do_wr) overflow <= 1'b1;
    end
  end

endmodule
`endif

// File: rtl/tmr_fault_monitor.sv
// TMR fault monitor: tracks voter outvotes per core, requests resync of a
// repeatedly outvoted core, escalates to FATAL on no-majority or ack timeout.
// Optional event log enabled by defining FAULT_LOG_EN.
module tmr_fault_monitor
  import tmr_fault_monitor_pkg::*;
#(
  parameter int unsigned CONSEC_THRESH = 3,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned ACK_TIMEOUT   = 16
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic [2:0]       Voter_state,
  input  logic             vote_valid,
  input  logic             resync_ack,
  input  logic             cnt_clr,
  input  logic             fatal_clr,
  output logic             resync_req,
  output logic [2:0]       resync_core,
  output logic             fatal,
  output logic [CNT_W-1:0] fault_cnt_a,
  output logic [CNT_W-1:0] fault_cnt_b,
  output logic [CNT_W-1:0] fault_cnt_c,
  output logic [7:0]       resync_cnt
`ifdef FAULT_LOG_EN
  ,
  input  logic             log_rd,
  output logic             log_empty,
  output logic             log_overflow,
  output logic [LOG_W-1:0] log_data
`endif
);

  localparam int unsigned TMO_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [3:0]       THRESH   = 4'(CONSEC_THRESH);

  state_e           state;
  logic [2:0]       suspect;
  logic [3:0]       consec;
  logic [3:0]       consec_inc;
  logic [TMO_W-1:0] tmo;
  logic [CNT_W-1:0] fault_cnt [3];
  vote_kind_e       vkind;
  logic [2:0]       core_hot;
  logic             v_single;
  logic             v_agree;
  logic             v_nomaj;

  // Decode the voter outcome, qualified by vote_valid.
  always_comb begin
    vkind      = classify_vote(Voter_state);
    core_hot   = outvoted_core(Voter_state);
    v_single   = vote_valid && (vkind == V_SINGLE);
    v_agree    = vote_valid && (vkind == V_AGREE);
    v_nomaj    = vote_valid && (vkind == V_NOMAJ);
    consec_inc = consec + 4'd1;
  end

  // Monitor FSM with registered resync_req / resync_core / fatal.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state       <= ST_MONITOR;
      suspect     <= '0;
      consec      <= '0;
      tmo         <= '0;
      resync_req  <= 1'b0;
      resync_core <= '0;
      fatal       <= 1'b0;
      resync_cnt  <= '0;
    end else begin
      case (state)
        ST_MONITOR: begin
          if (v_nomaj) begin
            state       <= ST_FATAL;
            fatal       <= 1'b1;
            resync_req  <= 1'b0;
            resync_core <= '0;
          end else if (v_single) begin
            suspect <= core_hot;
            consec  <= 4'd1;
            if (CONSEC_THRESH == 1) begin
              state       <= ST_RESYNC_REQ;
              resync_req  <= 1'b1;
              resync_core <= core_hot;
              tmo         <= '0;
            end else begin
              state <= ST_SUSPECT;
            end
          end
        end
        ST_SUSPECT: begin
          if (v_nomaj) begin
            state       <= ST_FATAL;
            fatal       <= 1'b1;
            resync_req  <= 1'b0;
            resync_core <= '0;
          end else if (v_agree) begin
            consec <= '0;
            state  <= ST_MONITOR;
          end else if (v_single) begin
            if (core_hot == suspect) begin
              consec <= consec_inc;
              if (consec_inc >= THRESH) begin
                state       <= ST_RESYNC_REQ;
                resync_req  <= 1'b1;
                resync_core <= suspect;
                tmo         <= '0;
              end
            end else begin
              suspect <= core_hot;
              consec  <= 4'd1;
            end
          end
        end
        ST_RESYNC_REQ: begin
          // Timeout advances every cycle regardless of vote_valid; an ack in
          // the last allowed cycle is checked before the timeout.
          if (v_nomaj) begin
            state       <= ST_FATAL;
            fatal       <= 1'b1;
            resync_req  <= 1'b0;
            resync_core <= '0;
            tmo         <= '0;
          end else if (resync_ack) begin
            state       <= ST_RESYNC_WAIT;
            resync_req  <= 1'b0;
            resync_core <= '0;
            tmo         <= '0;
          end else if (tmo == TMO_LAST) begin
            state       <= ST_FATAL;
            fatal       <= 1'b1;
            resync_req  <= 1'b0;
            resync_core <= '0;
            tmo         <= '0;
          end else begin
            tmo <= tmo + TMO_W'(1);
          end
        end
        ST_RESYNC_WAIT: begin
          if (v_nomaj) begin
            state <= ST_FATAL;
            fatal <= 1'b1;
          end else if (v_agree) begin
            if (resync_cnt != '1) resync_cnt <= resync_cnt + 8'd1;
            consec <= '0;
            state  <= ST_MONITOR;
          end
        end
        ST_FATAL: begin
          if (fatal_clr) begin
            state  <= ST_MONITOR;
            fatal  <= 1'b0;
            consec <= '0;
          end
        end
        default: begin
          state       <= ST_MONITOR;
          resync_req  <= 1'b0;
          resync_core <= '0;
          fatal       <= 1'b0;
        end
      endcase
    end
  end

  // Per-core saturating outvote counters; clear wins over increment.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      for (int unsigned i = 0; i < 3; i++) fault_cnt[i] <= '0;
    end else if (cnt_clr) begin
      for (int unsigned i = 0; i < 3; i++) fault_cnt[i] <= '0;
    end else if (v_single && (state != ST_FATAL)) begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (core_hot[i] && (fault_cnt[i] != '1)) fault_cnt[i] <= fault_cnt[i] + CNT_W'(1);
      end
    end
  end

  assign fault_cnt_a = fault_cnt[0];
  assign fault_cnt_b = fault_cnt[1];
  assign fault_cnt_c = fault_cnt[2];

`ifdef FAULT_LOG_EN
  logic [LOG_STAMP_W-1:0] stamp;
  logic                   log_wr;

  // Free-running cycle stamp for log entries.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) stamp <= '0;
    else         stamp <= stamp + LOG_STAMP_W'(1);
  end

  // Log every valid outcome other than full agreement.
  always_comb begin
    log_wr = vote_valid && (Voter_state != VOTE_AGREE);
  end

  fault_log_fifo #(
    .DEPTH (4),
    .W     (LOG_W)
  ) u_log (
    .clk      (clk),
    .rst_in   (rst_in),
    .wr_en    (log_wr),
    .wr_data  ({stamp, Voter_state}),
    .rd_en    (log_rd),
    .rd_data  (log_data),
    .empty    (log_empty),
    .overflow (log_overflow)
  );
`endif

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Self-checking bench for tmr_fault_monitor (default parameters).
module tb_tmr_fault_monitor;

  localparam int THRESH  = 3;
  localparam int TIMEOUT = 16;
  localparam int CMAX    = 255;

  localparam int M_MON = 0, M_SUS = 1, M_REQ = 2, M_WAIT = 3, M_FATAL = 4;

  logic       clk = 1'b0;
  logic       rst_in = 1'b0;
  logic [2:0] Voter_state = 3'b000;
  logic       vote_valid = 1'b0;
  logic       resync_ack = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       fatal_clr = 1'b0;
  logic       resync_req;
  logic [2:0] resync_core;
  logic       fatal;
  logic [7:0] fault_cnt_a, fault_cnt_b, fault_cnt_c;
  logic [7:0] resync_cnt;
`ifdef FAULT_LOG_EN
  logic        log_rd = 1'b0;
  logic        log_empty;
  logic        log_overflow;
  logic [18:0] log_data;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model state
  int m_mode, m_sus, m_run, m_waited, m_rcnt;
  int m_cnt[3];

  always #5 clk = ~clk;

  tmr_fault_monitor #(
    .CONSEC_THRESH (THRESH),
    .CNT_W         (8),
    .ACK_TIMEOUT   (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_in      (rst_in),
    .Voter_state (Voter_state),
    .vote_valid  (vote_valid),
    .resync_ack  (resync_ack),
    .cnt_clr     (cnt_clr),
    .fatal_clr   (fatal_clr),
    .resync_req  (resync_req),
    .resync_core (resync_core),
    .fatal       (fatal),
    .fault_cnt_a (fault_cnt_a),
    .fault_cnt_b (fault_cnt_b),
    .fault_cnt_c (fault_cnt_c),
    .resync_cnt  (resync_cnt)
`ifdef FAULT_LOG_EN
    ,
    .log_rd       (log_rd),
    .log_empty    (log_empty),
    .log_overflow (log_overflow),
    .log_data     (log_data)
`endif
  );

  // -1 full agreement, 0..2 outvoted core A/B/C, 3 no majority
  function automatic int vote_core(input logic [2:0] v);
    case (v)
      3'b000:  return -1;
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return 3;
    endcase
  endfunction

  function automatic void model_reset();
    m_mode = M_MON; m_sus = 0; m_run = 0; m_waited = 0; m_rcnt = 0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
  endfunction

  function automatic void model_step(input bit vv, input logic [2:0] vs, input bit ack,
                                     input bit cclr, input bit fclr);
    int c;
    c = vote_core(vs);
    if (cclr) begin
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    end else if (vv && c >= 0 && c < 3 && m_mode != M_FATAL && m_cnt[c] < CMAX) begin
      m_cnt[c] = m_cnt[c] + 1;
    end
    if (vv && c == 3 && m_mode != M_FATAL) begin
      m_mode = M_FATAL;
      return;
    end
    case (m_mode)
      M_MON: if (vv && c >= 0) begin
        m_sus = c; m_run = 1;
        if (m_run >= THRESH) begin m_mode = M_REQ; m_waited = 0; end
        else m_mode = M_SUS;
      end
      M_SUS: if (vv) begin
        if (c < 0) begin m_run = 0; m_mode = M_MON; end
        else if (c == m_sus) begin
          m_run = m_run + 1;
          if (m_run >= THRESH) begin m_mode = M_REQ; m_waited = 0; end
        end else begin m_sus = c; m_run = 1; end
      end
      M_REQ: begin
        if (ack) m_mode = M_WAIT;
        else begin
          m_waited = m_waited + 1;
          if (m_waited >= TIMEOUT) m_mode = M_FATAL;
        end
      end
      M_WAIT: if (vv && c < 0) begin
        if (m_rcnt < CMAX) m_rcnt = m_rcnt + 1;
        m_run = 0; m_mode = M_MON;
      end
      default: if (fclr) begin m_mode = M_MON; m_run = 0; end
    endcase
  endfunction

  // Apply one cycle of inputs; outputs are observed 1 time unit after the edge.
  task automatic drive(input bit vv, input logic [2:0] vs, input bit ack,
                       input bit cclr, input bit fclr);
    vote_valid = vv; Voter_state = vs; resync_ack = ack; cnt_clr = cclr; fatal_clr = fclr;
    @(posedge clk);
    model_step(vv, vs, ack, cclr, fclr);
    #1;
  endtask

  task automatic vote(input logic [2:0] vs);
    drive(1'b1, vs, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    vote_valid = 1'b0; Voter_state = 3'b000; resync_ack = 1'b0; cnt_clr = 1'b0; fatal_clr = 1'b0;
`ifdef FAULT_LOG_EN
    log_rd = 1'b0;
`endif
    rst_in = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    rst_in = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (resync_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", resync_req); end
    checks++; if (resync_core !== 3'b000) begin failures++; $display("FAIL reset_core got=%b exp=000", resync_core); end
    checks++; if (fatal !== 1'b0) begin failures++; $display("FAIL reset_fatal got=%b exp=0", fatal); end
    checks++; if (fault_cnt_a !== 8'd0) begin failures++; $display("FAIL reset_cnt_a got=%0d exp=0", fault_cnt_a); end
    checks++; if (fault_cnt_b !== 8'd0) begin failures++; $display("FAIL reset_cnt_b got=%0d exp=0", fault_cnt_b); end
    checks++; if (fault_cnt_c !== 8'd0) begin failures++; $display("FAIL reset_cnt_c got=%0d exp=0", fault_cnt_c); end
    checks++; if (resync_cnt !== 8'd0) begin failures++; $display("FAIL reset_rcnt got=%0d exp=0", resync_cnt); end
  endtask

  task automatic test_threshold();
    do_reset();
    vote(3'b001); vote(3'b001);
    checks++; if (resync_req !== 1'b0) begin failures++; $display("FAIL thr_early_req got=%b exp=0", resync_req); end
    vote(3'b001);
    checks++; if (resync_req !== 1'b1) begin failures++; $display("FAIL thr_req got=%b exp=1", resync_req); end
    checks++; if (resync_core !== 3'b001) begin failures++; $display("FAIL thr_core got=%b exp=001", resync_core); end
    checks++; if (fault_cnt_a !== 8'd3) begin failures++; $display("FAIL thr_cnt_a got=%0d exp=3", fault_cnt_a); end
    drive(1'b1, 3'b001, 1'b1, 1'b0, 1'b0);
    checks++; if (resync_req !== 1'b0) begin failures++; $display("FAIL thr_ack_req got=%b exp=0", resync_req); end
    checks++; if (fault_cnt_a !== 8'd4) begin failures++; $display("FAIL thr_cnt_a4 got=%0d exp=4", fault_cnt_a); end
    vote(3'b001);
    checks++; if (resync_cnt !== 8'd0) begin failures++; $display("FAIL thr_wait_ignore got=%0d exp=0", resync_cnt); end
    vote(3'b000);
    checks++; if (resync_cnt !== 8'd1) begin failures++; $display("FAIL thr_rcnt got=%0d exp=1", resync_cnt); end
  endtask

  task automatic test_switch();
    do_reset();
    vote(3'b001); vote(3'b010); vote(3'b010);
    checks++; if (resync_req !== 1'b0) begin failures++; $display("FAIL sw_early got=%b exp=0", resync_req); end
    vote(3'b010);
    checks++; if (resync_core !== 3'b010 || resync_req !== 1'b1) begin failures++;
      $display("FAIL sw_core got=%b/%b exp=010/1", resync_core, resync_req); end
    do_reset();
    vote(3'b001); vote(3'b001); vote(3'b000); vote(3'b001);
    checks++; if (resync_req !== 1'b0) begin failures++; $display("FAIL sw_agree_clear got=%b exp=0", resync_req); end
  endtask

  task automatic test_valid_gate();
    do_reset();
    vote(3'b001); vote(3'b001);
    repeat (5) drive(1'b0, 3'b001, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 3'b111, 1'b0, 1'b0, 1'b0);
    checks++; if (resync_req !== 1'b0 || fatal !== 1'b0) begin failures++;
      $display("FAIL gate_idle got=%b/%b exp=0/0", resync_req, fatal); end
    checks++; if (fault_cnt_a !== 8'd2) begin failures++; $display("FAIL gate_cnt got=%0d exp=2", fault_cnt_a); end
    vote(3'b001);
    checks++; if (resync_req !== 1'b1) begin failures++; $display("FAIL gate_resume got=%b exp=1", resync_req); end
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (3) vote(3'b100);
    repeat (TIMEOUT - 1) drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    checks++; if (fatal !== 1'b0 || resync_req !== 1'b1) begin failures++;
      $display("FAIL tmo_before got=%b/%b exp=0/1", fatal, resync_req); end
    drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    checks++; if (fatal !== 1'b1 || resync_req !== 1'b0) begin failures++;
      $display("FAIL tmo_fatal got=%b/%b exp=1/0", fatal, resync_req); end
    vote(3'b100);
    checks++; if (fault_cnt_c !== 8'd3) begin failures++; $display("FAIL tmo_fatal_cnt got=%0d exp=3", fault_cnt_c); end
    drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    checks++; if (fatal !== 1'b0) begin failures++; $display("FAIL tmo_clr got=%b exp=0", fatal); end
    repeat (3) vote(3'b010);
    checks++; if (resync_core !== 3'b010) begin failures++; $display("FAIL tmo_monitor got=%b exp=010", resync_core); end
    do_reset();
    repeat (3) vote(3'b001);
    repeat (TIMEOUT - 1) drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    checks++; if (fatal !== 1'b0 || resync_req !== 1'b0) begin failures++;
      $display("FAIL tmo_last_ack got=%b/%b exp=0/0", fatal, resync_req); end
  endtask

  task automatic test_saturate();
    do_reset();
    repeat (CMAX) begin vote(3'b010); vote(3'b000); end
    checks++; if (fault_cnt_b !== 8'd255) begin failures++; $display("FAIL sat_reach got=%0d exp=255", fault_cnt_b); end
    vote(3'b010);
    checks++; if (fault_cnt_b !== 8'd255) begin failures++; $display("FAIL sat_hold got=%0d exp=255", fault_cnt_b); end
    drive(1'b1, 3'b010, 1'b0, 1'b1, 1'b0);
    checks++; if (fault_cnt_b !== 8'd0) begin failures++; $display("FAIL sat_clr got=%0d exp=0", fault_cnt_b); end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (3) vote(3'b001);
    drive(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    vote(3'b000);
    repeat (3) vote(3'b010);
    checks++; if (resync_req !== 1'b1 || resync_cnt !== 8'd1) begin failures++;
      $display("FAIL arst_setup got=%b/%0d exp=1/1", resync_req, resync_cnt); end
    #2 rst_in = 1'b0;
    #1;
    checks++; if (resync_req !== 1'b0) begin failures++; $display("FAIL arst_req got=%b exp=0", resync_req); end
    checks++; if (resync_core !== 3'b000) begin failures++; $display("FAIL arst_core got=%b exp=000", resync_core); end
    checks++; if (resync_cnt !== 8'd0) begin failures++; $display("FAIL arst_rcnt got=%0d exp=0", resync_cnt); end
    checks++; if (fault_cnt_b !== 8'd0) begin failures++; $display("FAIL arst_cnt got=%0d exp=0", fault_cnt_b); end
    do_reset();
  endtask

  task automatic test_random();
    logic [2:0] odd_codes [3];
    logic [2:0] vs;
    logic [2:0] exp_core;
    bit vv, ack, cclr, fclr;
    int r;
    odd_codes[0] = 3'b011; odd_codes[1] = 3'b101; odd_codes[2] = 3'b110;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      vs = 3'b000;
      else if (r < 62) vs = 3'b001;
      else if (r < 76) vs = 3'b010;
      else if (r < 90) vs = 3'b100;
      else if (r < 94) vs = 3'b111;
      else             vs = odd_codes[$urandom_range(0, 2)];
      vv   = ($urandom_range(0, 99) < 75);
      ack  = ($urandom_range(0, 99) < 20);
      cclr = ($urandom_range(0, 99) < 2);
      fclr = ($urandom_range(0, 99) < 25);
      drive(vv, vs, ack, cclr, fclr);
      exp_core = 3'b000;
      if (m_mode == M_REQ) exp_core[m_sus] = 1'b1;
      checks++; if (resync_req !== (m_mode == M_REQ)) begin failures++;
        $display("FAIL rnd_req n=%0d got=%b exp=%b", n, resync_req, m_mode == M_REQ); end
      checks++; if (resync_core !== exp_core) begin failures++;
        $display("FAIL rnd_core n=%0d got=%b exp=%b", n, resync_core, exp_core); end
      checks++; if (fatal !== (m_mode == M_FATAL)) begin failures++;
        $display("FAIL rnd_fatal n=%0d got=%b exp=%b", n, fatal, m_mode == M_FATAL); end
      checks++; if (fault_cnt_a !== 8'(m_cnt[0])) begin failures++;
        $display("FAIL rnd_cnt_a n=%0d got=%0d exp=%0d", n, fault_cnt_a, m_cnt[0]); end
      checks++; if (fault_cnt_b !== 8'(m_cnt[1])) begin failures++;
        $display("FAIL rnd_cnt_b n=%0d got=%0d exp=%0d", n, fault_cnt_b, m_cnt[1]); end
      checks++; if (fault_cnt_c !== 8'(m_cnt[2])) begin failures++;
        $display("FAIL rnd_cnt_c n=%0d got=%0d exp=%0d", n, fault_cnt_c, m_cnt[2]); end
      checks++; if (resync_cnt !== 8'(m_rcnt)) begin failures++;
        $display("FAIL rnd_rcnt n=%0d got=%0d exp=%0d", n, resync_cnt, m_rcnt); end
    end
  endtask

`ifdef FAULT_LOG_EN
  task automatic test_log();
    logic [2:0]  exp_codes [5];
    logic [18:0] d;
    logic [15:0] first_stamp;
    exp_codes[0] = 3'b001; exp_codes[1] = 3'b010; exp_codes[2] = 3'b100;
    exp_codes[3] = 3'b111; exp_codes[4] = 3'b011;
    do_reset();
    for (int i = 0; i < 5; i++) vote(exp_codes[i]);
    checks++; if (log_overflow !== 1'b1) begin failures++; $display("FAIL log_ovf got=%b exp=1", log_overflow); end
    d = log_data;
    first_stamp = d[18:3];
    for (int i = 0; i < 4; i++) begin
      d = log_data;
      checks++; if (d[2:0] !== exp_codes[i] || d[18:3] !== first_stamp + 16'(i)) begin failures++;
        $display("FAIL log_entry%0d got=%h/%b exp=%h/%b", i, d[18:3], d[2:0], first_stamp + 16'(i), exp_codes[i]); end
      log_rd = 1'b1;
      drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
      log_rd = 1'b0;
    end
    checks++; if (log_empty !== 1'b1) begin failures++; $display("FAIL log_empty got=%b exp=1", log_empty); end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_threshold();
    test_switch();
    test_valid_gate();
    test_timeout();
    test_saturate();
    test_async_reset();
    test_random();
`ifdef FAULT_LOG_EN
    test_log();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
